// File: rtl/kgp_mem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, default widths
// and requester ids.
package kgp_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mem_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic R0 = 1'b0;
    localparam logic R1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the
// requester that was not served last.
module rr_arb2
    import kgp_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       grant_id,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        grant_id    = R0;
        if (req == 2'b11) begin
            grant_id = ~last_served;
        end else if (req[1]) begin
            grant_id = R1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port DataMemory between two req/ack requesters; one memory
// strobe per transaction, read data returned with a one-cycle ack.
module data_mem_arbiter
    import kgp_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_ack,
    output logic              r1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] mem_readData
);

    localparam int CNT_W = $clog2(READ_LATENCY + 1);

    mem_state_e        state_q, state_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic              last_served_q, last_served_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              r0_ack_q, r0_ack_d;
    logic              r1_ack_q, r1_ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              grant_id;
    logic              grant_valid;
    logic              gnt_we;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;

    rr_arb2 u_arb (
        .req         ({r1_req, r0_req}),
        .last_served (last_served_q),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign gnt_we    = (grant_id == R1) ? r1_we    : r0_we;
    assign gnt_addr  = (grant_id == R1) ? r1_addr  : r0_addr;
    assign gnt_wdata = (grant_id == R1) ? r1_wdata : r0_wdata;

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        we_d          = we_q;
        last_served_d = last_served_q;
        cnt_d         = cnt_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        r0_ack_d      = 1'b0;
        r1_ack_d      = 1'b0;
        rdata_d       = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    // Strobes are registered, so they rise together with ISSUE.
                    id_d          = grant_id;
                    last_served_d = grant_id;
                    we_d          = gnt_we;
                    mem_address_d = gnt_addr;
                    mem_wdata_d   = gnt_wdata;
                    mem_read_d    = ~gnt_we;
                    mem_write_d   = gnt_we;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    r0_ack_d = (id_q == R0);
                    r1_ack_d = (id_q == R1);
                    state_d  = RESP;
                end else begin
                    cnt_d   = CNT_W'(READ_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d  = mem_readData;
                    r0_ack_d = (id_q == R0);
                    r1_ack_d = (id_q == R1);
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            id_q          <= R0;
            we_q          <= 1'b0;
            last_served_q <= R1;
            cnt_q         <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            r0_ack_q      <= 1'b0;
            r1_ack_q      <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            we_q          <= we_d;
            last_served_q <= last_served_d;
            cnt_q         <= cnt_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            r0_ack_q      <= r0_ack_d;
            r1_ack_q      <= r1_ack_d;
            rdata_q       <= rdata_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign r0_ack        = r0_ack_q;
    assign r1_ack        = r1_ack_q;
    assign rdata         = rdata_q;
    assign mem_address   = mem_address_q;
    assign mem_writeData = mem_wdata_q;
    assign MemRead       = mem_read_q;
    assign MemWrite      = mem_write_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench: instance a (read latency 1) and instance b (read latency 3),
// each with a small behavioural DataMemory model.
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance a, READ_LATENCY = 1 ----------------
    logic        a_r0_req = 0, a_r0_we = 0, a_r1_req = 0, a_r1_we = 0;
    logic [31:0] a_r0_addr = 0, a_r0_wdata = 0, a_r1_addr = 0, a_r1_wdata = 0;
    logic        a_r0_ack, a_r1_ack, a_busy, a_MemRead, a_MemWrite;
    logic [31:0] a_rdata, a_mem_address, a_mem_writeData;
    logic [31:0] a_mem_readData = 0;
    logic [31:0] mem_a [0:15];

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .r0_req(a_r0_req), .r0_we(a_r0_we), .r0_addr(a_r0_addr), .r0_wdata(a_r0_wdata),
        .r1_req(a_r1_req), .r1_we(a_r1_we), .r1_addr(a_r1_addr), .r1_wdata(a_r1_wdata),
        .r0_ack(a_r0_ack), .r1_ack(a_r1_ack), .rdata(a_rdata), .busy(a_busy),
        .mem_address(a_mem_address), .mem_writeData(a_mem_writeData),
        .MemRead(a_MemRead), .MemWrite(a_MemWrite), .mem_readData(a_mem_readData)
    );

    always @(posedge clk) begin
        if (a_MemWrite) mem_a[a_mem_address[3:0]] <= a_mem_writeData;
        if (a_MemRead)  a_mem_readData <= mem_a[a_mem_address[3:0]];
    end

    // ---------------- instance b, READ_LATENCY = 3 ----------------
    logic        b_r0_req = 0, b_r0_we = 0, b_r1_req = 0, b_r1_we = 0;
    logic [31:0] b_r0_addr = 0, b_r0_wdata = 0, b_r1_addr = 0, b_r1_wdata = 0;
    logic        b_r0_ack, b_r1_ack, b_busy, b_MemRead, b_MemWrite;
    logic [31:0] b_rdata, b_mem_address, b_mem_writeData;
    logic [31:0] b_stage1 = 0, b_stage2 = 0, b_mem_readData = 0;
    logic [31:0] mem_b [0:15];

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata),
        .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
        .r0_ack(b_r0_ack), .r1_ack(b_r1_ack), .rdata(b_rdata), .busy(b_busy),
        .mem_address(b_mem_address), .mem_writeData(b_mem_writeData),
        .MemRead(b_MemRead), .MemWrite(b_MemWrite), .mem_readData(b_mem_readData)
    );

    // Read data appears three cycles after the edge that samples MemRead.
    always @(posedge clk) begin
        if (b_MemWrite) mem_b[b_mem_address[3:0]] <= b_mem_writeData;
        if (b_MemRead)  b_stage1 <= mem_b[b_mem_address[3:0]];
        b_stage2       <= b_stage1;
        b_mem_readData <= b_stage2;
    end

    always @(negedge clk) begin
        check_eq("strobe_excl_a", {63'd0, a_MemRead & a_MemWrite}, 64'd0);
        check_eq("strobe_excl_b", {63'd0, b_MemRead & b_MemWrite}, 64'd0);
    end

    // One transaction on instance a; called and returns at a negedge.
    task automatic do_txn(input logic who, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_lat,
                          input logic [31:0] exp_rdata, input string tag);
        int          ack_cyc = -1;
        int          strobes = 0;
        int          other   = 0;
        logic        s_kind  = 0;
        logic [31:0] s_addr  = 0, s_data = 0, rd = 0;
        if (who) begin
            a_r1_req = 1; a_r1_we = we; a_r1_addr = addr; a_r1_wdata = wdata;
        end else begin
            a_r0_req = 1; a_r0_we = we; a_r0_addr = addr; a_r0_wdata = wdata;
        end
        for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (a_MemRead || a_MemWrite) begin
                strobes++;
                s_kind = a_MemWrite;
                s_addr = a_mem_address;
                s_data = a_mem_writeData;
            end
            if (who ? a_r0_ack : a_r1_ack) other++;
            if (who ? a_r1_ack : a_r0_ack) begin
                ack_cyc = c;
                rd = a_rdata;
                a_r0_req = 0;
                a_r1_req = 0;
            end
        end
        check_eq({tag, "_lat"}, 64'(ack_cyc), 64'(exp_lat));
        check_eq({tag, "_nstrobe"}, 64'(strobes), 64'd1);
        check_eq({tag, "_kind"}, {63'd0, s_kind}, {63'd0, we});
        check_eq({tag, "_addr"}, {32'd0, s_addr}, {32'd0, addr});
        if (we) check_eq({tag, "_wdata"}, {32'd0, s_data}, {32'd0, wdata});
        else    check_eq({tag, "_rdata"}, {32'd0, rd}, {32'd0, exp_rdata});
        check_eq({tag, "_other_ack"}, 64'(other), 64'd0);
        @(negedge clk);
        check_eq({tag, "_ack_width"}, {63'd0, a_r0_ack | a_r1_ack}, 64'd0);
        check_eq({tag, "_idle"}, {63'd0, a_busy}, 64'd0);
    endtask

    // One r0 transaction on instance b; called and returns at a negedge.
    task automatic run_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int ack_cyc, output logic [31:0] rd, output int nstrobe);
        ack_cyc = -1; rd = 0; nstrobe = 0;
        b_r0_req = 1; b_r0_we = we; b_r0_addr = addr; b_r0_wdata = wdata;
        for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (b_MemRead || b_MemWrite) nstrobe++;
            if (b_r0_ack) begin
                ack_cyc = c;
                rd = b_rdata;
                b_r0_req = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int          exp_id  [4] = '{0, 1, 0, 1};
        int          exp_cyc [4] = '{3, 7, 11, 15};
        int          nacks;
        int          b_cyc, b_str;
        logic [31:0] b_rd;

        // 1: reset held with both requests active
        rst = 0; a_r0_req = 1; a_r1_req = 1;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_strobes", {62'd0, a_MemRead, a_MemWrite}, 64'd0);
            check_eq("rst_acks", {62'd0, a_r0_ack, a_r1_ack}, 64'd0);
            check_eq("rst_busy", {63'd0, a_busy}, 64'd0);
            check_eq("rst_rdata", {32'd0, a_rdata}, 64'd0);
            check_eq("rst_addr", {32'd0, a_mem_address}, 64'd0);
        end
        a_r0_req = 0; a_r1_req = 0; rst = 1;

        // 2, 3: write then read back from the other requester
        do_txn(1'b0, 1'b1, 32'd6, 32'd14, 2, 32'd0, "r0_wr6");
        check_eq("wr_keeps_rdata", {32'd0, a_rdata}, 64'd0);
        do_txn(1'b1, 1'b0, 32'd6, 32'd0, 3, 32'd14, "r1_rd6");
        do_txn(1'b0, 1'b1, 32'd5, 32'd9, 2, 32'd0, "r0_wr5");
        check_eq("wr_keeps_rdata2", {32'd0, a_rdata}, 64'd14);
        check_eq("idle_addr_hold", {32'd0, a_mem_address}, 64'd5);
        check_eq("idle_wdata_hold", {32'd0, a_mem_writeData}, 64'd9);

        // 4: fresh reset, both read together and keep re-requesting
        rst = 0;
        @(negedge clk);
        rst = 1;
        a_r0_req = 1; a_r0_we = 0; a_r0_addr = 5;
        a_r1_req = 1; a_r1_we = 0; a_r1_addr = 6;
        nacks = 0;
        for (int c = 1; c <= 40 && nacks < 4; c++) begin
            @(negedge clk);
            check_eq("dual_ack_excl", {63'd0, a_r0_ack & a_r1_ack}, 64'd0);
            if (a_r0_ack || a_r1_ack) begin
                check_eq($sformatf("dual_id%0d", nacks), {63'd0, a_r1_ack}, 64'(exp_id[nacks]));
                check_eq($sformatf("dual_cyc%0d", nacks), 64'(c), 64'(exp_cyc[nacks]));
                check_eq($sformatf("dual_rdata%0d", nacks), {32'd0, a_rdata},
                         (exp_id[nacks] == 1) ? 64'd14 : 64'd9);
                nacks++;
            end
        end
        a_r0_req = 0; a_r1_req = 0;
        check_eq("dual_nacks", 64'(nacks), 64'd4);
        @(negedge clk);
        @(negedge clk);
        check_eq("dual_idle", {63'd0, a_busy}, 64'd0);

        // 5: reset during the WAIT of an r0 read
        a_r0_req = 1; a_r0_we = 0; a_r0_addr = 6;
        @(negedge clk);
        @(negedge clk);
        check_eq("abort_in_wait", {63'd0, a_busy}, 64'd1);
        rst = 0; a_r0_req = 0;
        @(negedge clk);
        check_eq("abort_busy", {63'd0, a_busy}, 64'd0);
        check_eq("abort_ack", {62'd0, a_r0_ack, a_r1_ack}, 64'd0);
        check_eq("abort_strobes", {62'd0, a_MemRead, a_MemWrite}, 64'd0);
        check_eq("abort_rdata", {32'd0, a_rdata}, 64'd0);
        @(negedge clk);
        check_eq("abort_ack2", {63'd0, a_r0_ack}, 64'd0);
        rst = 1;
        @(negedge clk);
        do_txn(1'b0, 1'b0, 32'd6, 32'd0, 3, 32'd14, "post_abort_rd6");

        // 6: latency-3 instance
        run_b(1'b1, 32'd6, 32'd14, b_cyc, b_rd, b_str);
        check_eq("rl3_wr_lat", 64'(b_cyc), 64'd2);
        check_eq("rl3_wr_nstrobe", 64'(b_str), 64'd1);
        run_b(1'b0, 32'd6, 32'd0, b_cyc, b_rd, b_str);
        check_eq("rl3_rd_lat", 64'(b_cyc), 64'd5);
        check_eq("rl3_rd_rdata", {32'd0, b_rd}, 64'd14);
        check_eq("rl3_rd_nstrobe", 64'(b_str), 64'd1);
        check_eq("rl3_idle", {63'd0, b_busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
